// File: rtl/player_anim_sequencer.sv
// Per-frame player sprite animation controller: picks the animation from input
// state, steps the frame index and decodes the sprite-ROM base address and size.
module player_anim_sequencer #(
    parameter logic [20:0] IDLE_BASE   = 21'd0,
    parameter logic [20:0] RUN_BASE    = 21'd2432,
    parameter logic [20:0] UP_BASE     = 21'd19104,
    parameter logic [20:0] JUMP_BASE   = 21'd21680,
    parameter logic [20:0] DEAD_BASE   = 21'd28080,
    parameter logic [20:0] LEFT_OFFSET = 21'd50620,
    parameter int          FRAME_HOLD  = 4,
    parameter int          RUN_FRAMES  = 5,
    parameter int          JUMP_FRAMES = 4,
    parameter int          DEAD_FRAMES = 5
) (
    input  logic        frame_Clk,
    input  logic        Reset,
    input  logic [3:0]  keycode,
    input  logic        onGround,
    input  logic        hit,
    input  logic        respawn,
    output logic [2:0]  animState,
    output logic [3:0]  frameIdx,
    output logic        facingLeft,
    output logic [20:0] spriteBase,
    output logic [9:0]  PlayerHeight,
    output logic [9:0]  PlayerWidth,
    output logic        deadDone
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_UP   = 3'd2,
        S_JUMP = 3'd3,
        S_DEAD = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [3:0]  hold_cnt, hold_next;
    logic [3:0]  frame_next;
    logic        facing_next;
    logic        dead_done_next;
    logic        dead_latched, dead_latched_next;
    logic [20:0] base;
    logic [20:0] stride;

    assign animState = state;

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            frameIdx     <= 4'd0;
            hold_cnt     <= 4'd0;
            facingLeft   <= 1'b0;
            deadDone     <= 1'b0;
            dead_latched <= 1'b0;
        end else begin
            state        <= state_next;
            frameIdx     <= frame_next;
            hold_cnt     <= hold_next;
            facingLeft   <= facing_next;
            deadDone     <= dead_done_next;
            dead_latched <= dead_latched_next;
        end
    end

    always_comb begin
        state_next        = state;
        frame_next        = frameIdx;
        hold_next         = hold_cnt;
        facing_next       = facingLeft;
        dead_done_next    = 1'b0;
        dead_latched_next = dead_latched;

        if (state != S_DEAD) begin
            if (keycode == 4'd2)      facing_next = 1'b1;
            else if (keycode == 4'd3) facing_next = 1'b0;

            if (hit)                               state_next = S_DEAD;
            else if (!onGround || keycode == 4'd4) state_next = S_JUMP;
            else if (keycode == 4'd1)              state_next = S_UP;
            else if (keycode == 4'd2 || keycode == 4'd3) state_next = S_RUN;
            else                                   state_next = S_IDLE;
        end else if (respawn && dead_latched) begin
            // Death strip must have finished before respawn is honoured.
            state_next        = S_IDLE;
            dead_latched_next = 1'b0;
        end

        if (state_next != state) begin
            frame_next = 4'd0;
            hold_next  = 4'd0;
        end else if (hold_cnt == 4'(FRAME_HOLD - 1)) begin
            hold_next = 4'd0;
            case (state)
                S_RUN:  frame_next = (frameIdx == 4'(RUN_FRAMES - 1))  ? 4'd0 : frameIdx + 4'd1;
                S_JUMP: frame_next = (frameIdx == 4'(JUMP_FRAMES - 1)) ? 4'd0 : frameIdx + 4'd1;
                S_DEAD: begin
                    if (frameIdx != 4'(DEAD_FRAMES - 1)) begin
                        frame_next = frameIdx + 4'd1;
                    end else if (!dead_latched) begin
                        dead_done_next    = 1'b1;
                        dead_latched_next = 1'b1;
                    end
                end
                default: frame_next = 4'd0;
            endcase
        end else begin
            hold_next = hold_cnt + 4'd1;
        end
    end

    always_comb begin
        base         = IDLE_BASE;
        PlayerHeight = 10'd76;
        PlayerWidth  = 10'd32;
        case (state)
            S_RUN:  begin base = RUN_BASE;  PlayerHeight = 10'd76; PlayerWidth = 10'd32; end
            S_UP:   begin base = UP_BASE;   PlayerHeight = 10'd92; PlayerWidth = 10'd28; end
            S_JUMP: begin base = JUMP_BASE; PlayerHeight = 10'd40; PlayerWidth = 10'd40; end
            S_DEAD: begin base = DEAD_BASE; PlayerHeight = 10'd32; PlayerWidth = 10'd64; end
            default: ;
        endcase
    end

    // Each frame in a strip occupies W*H words; the mirrored bank sits above all strips.
    assign stride     = 21'(PlayerHeight) * 21'(PlayerWidth);
    assign spriteBase = base + 21'(frameIdx) * stride + (facingLeft ? LEFT_OFFSET : 21'd0);

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Directed bench for player_anim_sequencer: hand-computed frame sequences,
// ROM addresses, death/respawn handshake and reset recovery.
module tb_player_anim_sequencer;

    logic        frame_Clk = 1'b0;
    logic        Reset;
    logic [3:0]  keycode;
    logic        onGround;
    logic        hit;
    logic        respawn;
    logic [2:0]  animState;
    logic [3:0]  frameIdx;
    logic        facingLeft;
    logic [20:0] spriteBase;
    logic [9:0]  PlayerHeight;
    logic [9:0]  PlayerWidth;
    logic        deadDone;

    int checks   = 0;
    int failures = 0;
    int pulses;
    logic [31:0] exp_q[$];

    player_anim_sequencer dut (
        .frame_Clk    (frame_Clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .onGround     (onGround),
        .hit          (hit),
        .respawn      (respawn),
        .animState    (animState),
        .frameIdx     (frameIdx),
        .facingLeft   (facingLeft),
        .spriteBase   (spriteBase),
        .PlayerHeight (PlayerHeight),
        .PlayerWidth  (PlayerWidth),
        .deadDone     (deadDone)
    );

    always #5 frame_Clk = ~frame_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_Clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] k, input logic g, input logic h, input logic r);
        keycode  = k;
        onGround = g;
        hit      = h;
        respawn  = r;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  32'(animState),    32'd0);
        check({tag, "_frame"},  32'(frameIdx),     32'd0);
        check({tag, "_facing"}, 32'(facingLeft),   32'd0);
        check({tag, "_base"},   32'(spriteBase),   32'd0);
        check({tag, "_h"},      32'(PlayerHeight), 32'd76);
        check({tag, "_w"},      32'(PlayerWidth),  32'd32);
        check({tag, "_done"},   32'(deadDone),     32'd0);
    endtask

    initial begin
        // Reset
        Reset = 1'b1;
        drive(4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check_reset("rst");
        Reset = 1'b0;

        // Run strip: frame advances every 4 edges, wraps after 5 frames
        drive(4'd3, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 10; n++) exp_q.push_back(32'(((n - 1) / 4) % 5));
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) check("run_state", 32'(animState), 32'd1);
            check("run_frame", 32'(frameIdx), exp_q.pop_front());
        end
        check("run_base_f2", 32'(spriteBase), 32'd7296);
        for (int n = 11; n <= 30; n++) begin
            tick();
            if (n == 21) check("run_wrap", 32'(frameIdx), 32'd0);
        end
        check("run_frame_30", 32'(frameIdx), 32'd2);

        // Face left while running, then aim up
        drive(4'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check("left_facing", 32'(facingLeft), 32'd1);
        check("left_state",  32'(animState),  32'd1);
        check("left_base",   32'(spriteBase), 32'd57916);
        drive(4'd1, 1'b1, 1'b0, 1'b0);
        tick();
        check("up_state", 32'(animState),    32'd2);
        check("up_base",  32'(spriteBase),   32'd69724);
        check("up_h",     32'(PlayerHeight), 32'd92);
        check("up_w",     32'(PlayerWidth),  32'd28);
        check("up_frame", 32'(frameIdx),     32'd0);

        // Run to frame 3, then leave the ground
        drive(4'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check("run2_facing", 32'(facingLeft), 32'd0);
        for (int n = 0; n < 12; n++) tick();
        check("run2_frame", 32'(frameIdx),   32'd3);
        check("run2_base",  32'(spriteBase), 32'd9728);
        drive(4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        check("jump_state", 32'(animState),    32'd3);
        check("jump_frame", 32'(frameIdx),     32'd0);
        check("jump_base",  32'(spriteBase),   32'd21680);
        check("jump_h",     32'(PlayerHeight), 32'd40);
        check("jump_w",     32'(PlayerWidth),  32'd40);
        drive(4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check("land_idle", 32'(animState), 32'd0);
        drive(4'd9, 1'b1, 1'b0, 1'b0);
        tick();
        check("bad_key_idle", 32'(animState), 32'd0);

        // Death: early respawn and repeated hit are ignored, one deadDone pulse
        drive(4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check("dead_state", 32'(animState),    32'd4);
        check("dead_frame", 32'(frameIdx),     32'd0);
        check("dead_base",  32'(spriteBase),   32'd28080);
        check("dead_h",     32'(PlayerHeight), 32'd32);
        check("dead_w",     32'(PlayerWidth),  32'd64);
        pulses = 0;
        for (int e = 2; e <= 21; e++) begin
            drive(4'd0, 1'b1, (e == 10), 1'b1);
            tick();
            if (deadDone) pulses++;
            check("dead_hold", 32'(animState), 32'd4);
            if (e == 17) check("dead_frame4", 32'(frameIdx), 32'd4);
            if (e == 20) check("dead_done_early", 32'(deadDone), 32'd0);
            if (e == 21) check("dead_done", 32'(deadDone), 32'd1);
        end
        for (int e = 22; e <= 29; e++) begin
            drive(4'd0, 1'b1, 1'b0, 1'b0);
            tick();
            if (deadDone) pulses++;
        end
        check("dead_pulses",   32'(pulses),     32'd1);
        check("dead_sat",      32'(frameIdx),   32'd4);
        check("dead_base_f4",  32'(spriteBase), 32'd36272);
        check("dead_stay",     32'(animState),  32'd4);
        drive(4'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check("respawn_state", 32'(animState), 32'd0);
        check("respawn_frame", 32'(frameIdx),  32'd0);
        check("respawn_done",  32'(deadDone),  32'd0);

        // Reset mid-jump at frame 2, keycode 4 outranks ground, reset mid-death
        drive(4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check("jump2_state",  32'(animState),  32'd3);
        check("jump2_facing", 32'(facingLeft), 32'd1);
        for (int n = 0; n < 8; n++) tick();
        check("jump2_frame", 32'(frameIdx),   32'd2);
        check("jump2_base",  32'(spriteBase), 32'd75500);
        Reset = 1'b1;
        tick();
        check_reset("rst_jump");
        Reset = 1'b0;
        drive(4'd4, 1'b1, 1'b0, 1'b0);
        tick();
        check("key_jump", 32'(animState), 32'd3);
        drive(4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(4'd0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) tick();
        check("dead2_frame", 32'(frameIdx), 32'd1);
        Reset = 1'b1;
        tick();
        check_reset("rst_dead");
        Reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
